mem_req_queue: RTL and testbench

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

---
 rtl/mem_req_queue.sv | 159 +++++++++++++++
 tb/tb_mem_req_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order memory request queue.
// Accepted {we, addr, data} requests are held in a circular FIFO and issued
// one per cycle to a combinational-read memory. Read results are captured
// into a single response register that holds until consumed.
// Optional feature: define MEM_REQ_BYPASS_EN to let a request arriving at an
// empty queue issue in its accept cycle without passing through the FIFO.
module mem_req_queue #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ASIZE-1:0]             req_addr,
  input  logic [DSIZE-1:0]             req_data,
  output logic                         we,
  output logic [ASIZE-1:0]             addr,
  output logic [DSIZE-1:0]             mem_in,
  input  logic [DSIZE-1:0]             mem_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DSIZE-1:0]             rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Queue storage; only the head entry is ever read, combinationally.
  logic [DEPTH-1:0] q_we_reg;
  logic [ASIZE-1:0] q_addr_reg [DEPTH];
  logic [DSIZE-1:0] q_data_reg [DEPTH];

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             rsp_valid_reg;
  logic [DSIZE-1:0] rsp_data_reg;

  logic             head_we;
  logic [ASIZE-1:0] head_addr;
  logic [DSIZE-1:0] head_data;
  logic             accept;
  logic             fifo_issue;
  logic             bypass_issue;
  logic             push;
  logic             pop;
  logic             issue;
  logic             issue_we;
  logic [ASIZE-1:0] issue_addr;
  logic [DSIZE-1:0] issue_data;

  assign head_we   = q_we_reg[rd_ptr_reg];
  assign head_addr = q_addr_reg[rd_ptr_reg];
  assign head_data = q_data_reg[rd_ptr_reg];

  // Full blocks acceptance even when the head pops in the same cycle.
  assign req_ready = (count_reg < FULL);
  assign accept    = req_valid && req_ready;

  // Writes never wait on the response slot; reads need it free or draining.
  assign fifo_issue = (count_reg != '0) && (head_we || !rsp_valid_reg || rsp_ready);

`ifdef MEM_REQ_BYPASS_EN
  assign bypass_issue = accept && (count_reg == '0) && (req_we || !rsp_valid_reg || rsp_ready);
`else
  assign bypass_issue = 1'b0;
`endif

  // A bypassed request never occupies a slot; the two issue sources are
  // exclusive because bypass needs an empty queue.
  assign push  = accept && !bypass_issue;
  assign pop   = fifo_issue;
  assign issue = (fifo_issue || bypass_issue) && !rst;

  // Select the issuing request and drive the memory port, idle at zero.
  always_comb begin
    issue_we   = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    if (fifo_issue) begin
      issue_we   = head_we;
      issue_addr = head_addr;
      issue_data = head_data;
    end else if (bypass_issue) begin
      issue_we   = req_we;
      issue_addr = req_addr;
      issue_data = req_data;
    end
    we     = 1'b0;
    addr   = '0;
    mem_in = '0;
    if (issue) begin
      we     = issue_we;
      addr   = issue_addr;
      mem_in = issue_we ? issue_data : '0;
    end
  end

  // Per-entry storage write at the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the pushed request into this slot.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          q_we_reg[gi]   <= req_we;
          q_addr_reg[gi] <= req_addr;
          q_data_reg[gi] <= req_data;
        end
      end
    end
  endgenerate

  // Pointer and occupancy next-state; pointers wrap naturally (power of two).
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (pop && !push) count_next = count_reg - CW'(1);
  end

  // Queue control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Response slot: load on a read issue, clear when consumed with no reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else if (issue && !issue_we) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= mem_out;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed testbench for mem_req_queue with a behavioural memory model.
module tb_mem_req_queue;

`ifdef MEM_REQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       we;
  logic [7:0] addr;
  logic [7:0] mem_in;
  logic [7:0] mem_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_model [256];
  logic [15:0] wr_log [$];
  logic [7:0]  rsp_log [$];

  always #5 clk = ~clk;

  mem_req_queue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .we(we), .addr(addr), .mem_in(mem_in), .mem_out(mem_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .count(count)
  );

  assign mem_out = mem_model[addr];

  always @(posedge clk) begin
    if (we) mem_model[addr] <= mem_in;
    if (!rst) begin
      if (we) wr_log.push_back({addr, mem_in});
      if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Offer one request and hold it until accepted (bounded).
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_addr = a; req_data = d;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (!req_ready) begin
      bad++; $display("FAIL send_timeout: req_ready=%0b required 1 addr=%h", req_ready, a);
    end
    $display("send we=%0b addr=%h data=%h", w, a, d);
    @(posedge clk);
  endtask

  task automatic test_reset();
    #2;
    total++; if (count !== 3'd0)   begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
    total++; if (we !== 1'b0)      begin bad++; $display("FAIL rst_we: got %0b want 0", we); end
    total++; if (addr !== 8'h00)   begin bad++; $display("FAIL rst_addr: got %h want 00", addr); end
    total++; if (mem_in !== 8'h00) begin bad++; $display("FAIL rst_mem_in: got %h want 00", mem_in); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    $display("reset checked");
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read();
    int wcyc = -1, rcyc = -1, nrsp = 0;
    logic [7:0] rdat = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_data = 8'h5A;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (we && addr == 8'h12 && wcyc < 0) wcyc = k;
      if (rsp_valid) begin
        if (rcyc < 0) begin rcyc = k; rdat = rsp_data; end
        nrsp++;
      end
      @(negedge clk);
      if (k == 0) begin req_we = 1'b0; req_data = 8'h00; end
      if (k == 1) req_valid = 1'b0;
      #1;
    end
    total++; if (wcyc !== LAT) begin bad++; $display("FAIL wr_issue_cycle: got %0d want %0d", wcyc, LAT); end
    total++; if (rcyc !== wcyc + 2) begin bad++; $display("FAIL rd_rsp_cycle: got %0d want %0d", rcyc, wcyc + 2); end
    total++; if (nrsp !== 1) begin bad++; $display("FAIL rd_rsp_pulses: got %0d want 1", nrsp); end
    total++; if (rdat !== 8'h5A) begin bad++; $display("FAIL rd_rsp_data: got %h want 5a", rdat); end
    $display("write_read: wcyc=%0d rcyc=%0d data=%h", wcyc, rcyc, rdat);
  endtask

  task automatic test_single_write();
    int first = -1, nwe = 0;
    logic [7:0] a = '0, d = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_data = 8'hC3;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (we) begin
        if (first < 0) begin first = k; a = addr; d = mem_in; end
        nwe++;
      end
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      #1;
    end
    total++; if (first !== LAT) begin bad++; $display("FAIL wr_latency: got %0d want %0d", first, LAT); end
    total++; if (nwe !== 1) begin bad++; $display("FAIL wr_width: got %0d want 1", nwe); end
    total++; if (a !== 8'h12) begin bad++; $display("FAIL wr_addr: got %h want 12", a); end
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL wr_data: got %h want c3", d); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wr_count: got %0d want 0", count); end
    $display("single_write: latency=%0d addr=%h data=%h", first, a, d);
  endtask

  task automatic test_stall();
    int rbase, wbase;
    rsp_ready = 1'b1;
    send(1'b1, 8'h01, 8'h11); send(1'b1, 8'h03, 8'h33); send(1'b1, 8'h04, 8'h44);
    idle(); wait_cycles(4);
    rbase = rsp_log.size(); wbase = wr_log.size();
    rsp_ready = 1'b0;
    send(1'b0, 8'h01, 8'h00); send(1'b0, 8'h04, 8'h00);
    send(1'b1, 8'h02, 8'h22); send(1'b0, 8'h03, 8'h00);
    idle(); wait_cycles(2);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %0b want 1", rsp_valid); end
      total++; if (rsp_data !== 8'h11) begin bad++; $display("FAIL stall_data: got %h want 11", rsp_data); end
      total++; if (count !== 3'd3) begin bad++; $display("FAIL stall_count: got %0d want 3", count); end
      total++; if (wr_log.size() !== wbase) begin bad++; $display("FAIL stall_no_write: got %0d writes want %0d", wr_log.size(), wbase); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h44) begin
      bad++; $display("FAIL reload_no_bubble: got valid=%0b data=%h want 1/44", rsp_valid, rsp_data); end
    wait_cycles(8);
    total++;
    if (rsp_log.size() !== rbase + 3) begin
      bad++; $display("FAIL stall_rsp_count: got %0d want %0d", rsp_log.size(), rbase + 3);
    end else if (rsp_log[rbase] !== 8'h11 || rsp_log[rbase+1] !== 8'h44 || rsp_log[rbase+2] !== 8'h33) begin
      bad++; $display("FAIL stall_rsp_order: got %h %h %h want 11 44 33", rsp_log[rbase], rsp_log[rbase+1], rsp_log[rbase+2]);
    end
    total++;
    if (wr_log.size() !== wbase + 1) begin
      bad++; $display("FAIL stall_wr_count: got %0d want %0d", wr_log.size(), wbase + 1);
    end else if (wr_log[wbase] !== 16'h0222) begin
      bad++; $display("FAIL stall_wr_entry: got %h want 0222", wr_log[wbase]);
    end
    $display("stall: responses=%0d writes=%0d", rsp_log.size() - rbase, wr_log.size() - wbase);
  endtask

  task automatic test_full_wrap();
    int rbase, wbase;
    logic [7:0] exp_rsp [8];
    rbase = rsp_log.size(); wbase = wr_log.size();
    rsp_ready = 1'b0;
    send(1'b0, 8'h01, 8'h00);
    send(1'b0, 8'h04, 8'h00); send(1'b1, 8'h20, 8'hB0);
    send(1'b0, 8'h20, 8'h00); send(1'b1, 8'h21, 8'hB1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h21; req_data = 8'h00;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", req_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", count); end
    repeat (2) begin
      @(negedge clk); #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_hold: got %0d want 4", count); end
    end
    rsp_ready = 1'b1;
    send(1'b0, 8'h21, 8'h00);
    for (int i = 0; i < 4; i++) send(1'b1, 8'h30 + 8'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) send(1'b0, 8'h30 + 8'(i), 8'h00);
    idle(); wait_cycles(12);
    exp_rsp[0] = 8'h11; exp_rsp[1] = 8'h44; exp_rsp[2] = 8'hB0; exp_rsp[3] = 8'hB1;
    for (int i = 0; i < 4; i++) exp_rsp[4+i] = 8'hC0 + 8'(i);
    total++;
    if (rsp_log.size() !== rbase + 8) begin
      bad++; $display("FAIL wrap_rsp_count: got %0d want %0d", rsp_log.size(), rbase + 8);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rsp_log[rbase+i] !== exp_rsp[i]) begin
          bad++; $display("FAIL wrap_rsp_%0d: got %h want %h", i, rsp_log[rbase+i], exp_rsp[i]);
        end
      end
    end
    total++;
    if (wr_log.size() !== wbase + 6) begin
      bad++; $display("FAIL wrap_wr_count: got %0d want %0d", wr_log.size(), wbase + 6);
    end else if (wr_log[wbase] !== 16'h20B0 || wr_log[wbase+1] !== 16'h21B1 || wr_log[wbase+5] !== 16'h33C3) begin
      bad++; $display("FAIL wrap_wr_order: got %h %h %h want 20b0 21b1 33c3", wr_log[wbase], wr_log[wbase+1], wr_log[wbase+5]);
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_drain: got %0d want 0", count); end
    $display("full_wrap: responses=%0d writes=%0d", rsp_log.size() - rbase, wr_log.size() - wbase);
  endtask

  task automatic test_reset_mid();
    int rbase, wbase;
    rsp_ready = 1'b0;
    send(1'b0, 8'h01, 8'h00); send(1'b0, 8'h04, 8'h00);
    send(1'b1, 8'h40, 8'hDD); send(1'b0, 8'h40, 8'h00);
    idle(); #1;
    total++; if (count !== 3'd3 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL mid_setup: got count=%0d valid=%0b want 3/1", count, rsp_valid); end
    rbase = rsp_log.size(); wbase = wr_log.size();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mid_we: got %0b want 0", we); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", count); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid: got %0b want 0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %0b want 1", req_ready); end
    wait_cycles(2);
    rst = 1'b0; rsp_ready = 1'b1;
    wait_cycles(6); #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL post_count: got %0d want 0", count); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL post_rsp_valid: got %0b want 0", rsp_valid); end
    total++; if (wr_log.size() !== wbase) begin bad++; $display("FAIL post_no_write: got %0d want %0d", wr_log.size(), wbase); end
    total++; if (rsp_log.size() !== rbase) begin bad++; $display("FAIL post_no_rsp: got %0d want %0d", rsp_log.size(), rbase); end
    $display("reset_mid: count=%0d rsp_valid=%0b", count, rsp_valid);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_single_write();
    test_stall();
    test_full_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
